// File: rtl/reg_xfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_xfer_sequencer_pkg : register/source/op codes and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg_xfer_sequencer_pkg;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_X = 2'd1;
  localparam logic [1:0] REG_Y = 2'd2;
  localparam logic [1:0] REG_S = 2'd3;

  // Sources 0..3 alias the register codes; anything above SRC_DB is illegal.
  localparam logic [2:0] SRC_DB = 3'd4;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic logic [3:0] reg_onehot(input logic [1:0] i_reg);
    return 4'b0001 << i_reg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_xfer_sequencer_incdec8.sv
// ---------------------------------------------------------------------------
// incdec8 : combinational pass / increment / decrement with N/Z generation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module incdec8
  import reg_xfer_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_n,
  output logic             o_z
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  always_comb begin
    o_y = i_a;
    case (i_op)
      OP_INC:  o_y = i_a + C_ONE;
      OP_DEC:  o_y = i_a - C_ONE;
      default: o_y = i_a;
    endcase
  end

  assign o_n = o_y[WIDTH-1];
  assign o_z = (o_y == '0);

endmodule

`default_nettype wire

// File: rtl/reg_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// reg_xfer_sequencer : A/X/Y/S register-transfer sequencer with N/Z update
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_xfer_sequencer
  import reg_xfer_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [2:0]       REQ_SRC,
  input  logic [1:0]       REQ_DST,
  input  logic [1:0]       REQ_OP,
  input  logic             REQ_FLAGS,
  input  logic [WIDTH-1:0] A_Q,
  input  logic [WIDTH-1:0] X_Q,
  input  logic [WIDTH-1:0] Y_Q,
  input  logic [WIDTH-1:0] S_Q,
  input  logic [WIDTH-1:0] DB_IN,
  output logic [WIDTH-1:0] BUS,
  output logic [3:0]       CE,
  output logic             FLAG_CE,
  output logic             FLAG_N,
  output logic             FLAG_Z,
  output logic             DONE,
  output logic             ERR
);

  state_t           r_state;
  logic [2:0]       r_src;
  logic [1:0]       r_dst;
  logic [1:0]       r_op;
  logic             r_flags;
  logic [WIDTH-1:0] w_src_val;
  logic [WIDTH-1:0] w_res;
  logic             w_res_n;
  logic             w_res_z;
  logic             w_illegal;

  // Gated by RST so the block never advertises readiness while held in reset.
  assign REQ_READY = (r_state == ST_IDLE) && !RST;
  assign w_illegal = (r_src > SRC_DB) || (r_op == OP_ILL);

  always_comb begin
    w_src_val = '0;
    case (r_src)
      {1'b0, REG_A}: w_src_val = A_Q;
      {1'b0, REG_X}: w_src_val = X_Q;
      {1'b0, REG_Y}: w_src_val = Y_Q;
      {1'b0, REG_S}: w_src_val = S_Q;
      SRC_DB:        w_src_val = DB_IN;
      default:       w_src_val = '0;
    endcase
  end

  incdec8 #(
    .WIDTH (WIDTH)
  ) u_incdec (
    .i_a  (w_src_val),
    .i_op (r_op),
    .o_y  (w_res),
    .o_n  (w_res_n),
    .o_z  (w_res_z)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_op    <= '0;
      r_flags <= 1'b0;
      BUS     <= '0;
      CE      <= '0;
      FLAG_CE <= 1'b0;
      FLAG_N  <= 1'b0;
      FLAG_Z  <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      CE      <= '0;
      FLAG_CE <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            r_src   <= REQ_SRC;
            r_dst   <= REQ_DST;
            r_op    <= REQ_OP;
            r_flags <= REQ_FLAGS;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The source is sampled here and only here; BUS acts as the temp.
          if (w_illegal) begin
            DONE    <= 1'b1;
            ERR     <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            BUS <= w_res;
            CE  <= reg_onehot(r_dst);
            if (r_flags) begin
              FLAG_CE <= 1'b1;
              FLAG_N  <= w_res_n;
              FLAG_Z  <= w_res_z;
            end
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          DONE    <= 1'b1;
          r_state <= ST_FINISH;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
